// File: rtl/tinydfu_boot_ctrl.sv
// Boot controller for a USB DFU bootloader.
// Sequence: hold core in reset, wait for DFU activity or autoboot, drop pull-up, trigger multiboot.
module tinydfu_boot_ctrl #(
  parameter longint unsigned RESET_CYCLES      = 65535,
  parameter longint unsigned BOOT_TIMEOUT      = 60000000,
  parameter longint unsigned DISCONNECT_CYCLES = 12000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] dfu_state,
  input  logic       dfu_detach,
  output logic       core_reset,
  output logic       usb_pull_en,
  output logic       boot_req,
  output logic [2:0] ctrl_state,
  output logic       autoboot_armed
);

  localparam longint unsigned Max32 = 64'h0000_0000_FFFF_FFFF;

  // Counter loads saturate at the 32-bit maximum.
  localparam logic [31:0] ResetLoad   = (RESET_CYCLES > Max32) ? 32'hFFFF_FFFF
                                                               : 32'(RESET_CYCLES);
  localparam logic [31:0] TimeoutLoad = (BOOT_TIMEOUT > Max32) ? 32'hFFFF_FFFF
                                                               : 32'(BOOT_TIMEOUT);
  localparam logic [31:0] DiscLoad    = (DISCONNECT_CYCLES > Max32) ? 32'hFFFF_FFFF
                                                                    : 32'(DISCONNECT_CYCLES);
  localparam logic        AutobootEn  = (TimeoutLoad != 32'd0);

  typedef enum logic [2:0] {
    StHold = 3'd0,
    StWait = 3'd1,
    StDfu  = 3'd2,
    StDisc = 3'd3,
    StBoot = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        core_reset_d, usb_pull_en_d, boot_req_d, autoboot_armed_d;
  logic        cnt_zero;

  assign cnt_zero   = (cnt_q == 32'd0);
  assign ctrl_state = state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StHold;
      cnt_q          <= ResetLoad;
      core_reset     <= 1'b1;
      usb_pull_en    <= 1'b0;
      boot_req       <= 1'b0;
      autoboot_armed <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      core_reset     <= core_reset_d;
      usb_pull_en    <= usb_pull_en_d;
      boot_req       <= boot_req_d;
      autoboot_armed <= autoboot_armed_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_zero ? 32'd0 : cnt_q - 32'd1;
    case (state_q)
      StHold: begin
        if (cnt_zero) begin
          state_d = StWait;
          cnt_d   = TimeoutLoad;
        end
      end
      StWait: begin
        // Detach outranks DFU activity, which in turn cancels a same-cycle timeout.
        if (dfu_detach) begin
          state_d = StDisc;
          cnt_d   = DiscLoad;
        end else if (dfu_state > 8'd2) begin
          state_d = StDfu;
        end else if (cnt_zero && AutobootEn) begin
          state_d = StDisc;
          cnt_d   = DiscLoad;
        end
      end
      StDfu: begin
        if (dfu_detach) begin
          state_d = StDisc;
          cnt_d   = DiscLoad;
        end
      end
      StDisc: begin
        if (cnt_zero) state_d = StBoot;
      end
      StBoot: state_d = StBoot;
      default: begin
        state_d = StHold;
        cnt_d   = ResetLoad;
      end
    endcase
  end

  // Outputs decoded from the next state so they are registered alongside it.
  always_comb begin
    core_reset_d     = 1'b0;
    usb_pull_en_d    = 1'b0;
    boot_req_d       = 1'b0;
    autoboot_armed_d = 1'b0;
    case (state_d)
      StHold: core_reset_d = 1'b1;
      StWait: begin
        usb_pull_en_d    = 1'b1;
        autoboot_armed_d = AutobootEn;
      end
      StDfu:  usb_pull_en_d = 1'b1;
      StDisc: ;
      StBoot: begin
        core_reset_d = 1'b1;
        boot_req_d   = 1'b1;
      end
      default: core_reset_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_tinydfu_boot_ctrl.sv
// Bench for tinydfu_boot_ctrl: vector table, directed corner sequences and random run
// against a phase/elapsed-time reference model; two instances (autoboot on and off).
module tb_tinydfu_boot_ctrl;

  localparam int R = 4;
  localparam int T = 20;
  localparam int D = 3;

  logic       clk = 1'b0;
  logic       rst[2];
  logic       det[2];
  logic [7:0] st[2];
  logic       cr[2], pe[2], br[2], aa[2];
  logic [2:0] cs[2];

  always #5 clk = ~clk;

  tinydfu_boot_ctrl #(.RESET_CYCLES(R), .BOOT_TIMEOUT(T), .DISCONNECT_CYCLES(D)) dut_a (
    .clk(clk), .reset(rst[0]), .dfu_state(st[0]), .dfu_detach(det[0]),
    .core_reset(cr[0]), .usb_pull_en(pe[0]), .boot_req(br[0]),
    .ctrl_state(cs[0]), .autoboot_armed(aa[0])
  );

  tinydfu_boot_ctrl #(.RESET_CYCLES(R), .BOOT_TIMEOUT(0), .DISCONNECT_CYCLES(D)) dut_b (
    .clk(clk), .reset(rst[1]), .dfu_state(st[1]), .dfu_detach(det[1]),
    .core_reset(cr[1]), .usb_pull_en(pe[1]), .boot_req(br[1]),
    .ctrl_state(cs[1]), .autoboot_armed(aa[1])
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0..4 = hold, wait, dfu, disc, boot; age = cycles spent in phase.
  int m_phase[2];
  int m_age[2];
  int m_tmo[2] = '{T, 0};

  function automatic void go(input int i, input int p);
    m_phase[i] = p;
    m_age[i]   = 0;
  endfunction

  function automatic void model_step(input int i);
    if (rst[i]) begin
      go(i, 0);
    end else begin
      case (m_phase[i])
        0: if (m_age[i] >= R) go(i, 1); else m_age[i]++;
        1: begin
          if (det[i]) go(i, 3);
          else if (st[i] > 2) go(i, 2);
          else if (m_tmo[i] != 0 && m_age[i] >= m_tmo[i]) go(i, 3);
          else m_age[i]++;
        end
        2: if (det[i]) go(i, 3);
        3: if (m_age[i] >= D) go(i, 4); else m_age[i]++;
        default: ;
      endcase
    end
  endfunction

  function automatic logic [6:0] model_out(input int i);
    logic [2:0] p;
    p = 3'(m_phase[i]);
    return {p, (p == 0 || p == 4), (p == 1 || p == 2), (p == 4), (p == 1 && m_tmo[i] != 0)};
  endfunction

  function automatic logic [6:0] dut_out(input int i);
    return {cs[i], cr[i], pe[i], br[i], aa[i]};
  endfunction

  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_step(i);
    #1;
    check("model_a", 32'(dut_out(0)), 32'(model_out(0)));
    check("model_b", 32'(dut_out(1)), 32'(model_out(1)));
  endtask

  task automatic idle(input int i);
    rst[i] = 1'b0; det[i] = 1'b0; st[i] = 8'd0;
  endtask

  task automatic reset_pulse(input int i);
    rst[i] = 1'b1; det[i] = 1'b0; st[i] = 8'd0;
    tick();
    idle(i);
  endtask

  typedef struct {
    logic       r;
    logic       d;
    logic [7:0] s;
    logic [6:0] exp;
  } vec_t;

  localparam logic [6:0] OHold = 7'b000_1000;
  localparam logic [6:0] OWait = 7'b001_0101;
  localparam logic [6:0] ODfu  = 7'b010_0100;
  localparam logic [6:0] ODisc = 7'b011_0000;
  localparam logic [6:0] OBoot = 7'b100_1010;

  vec_t tbl[$];
  int   first_low, high_cnt, disc_cnt, first_boot, seen_boot;

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; det[i] = 1'b0; st[i] = 8'd0;
    end

    // Vector table on instance A (instance B held in reset).
    tbl.push_back('{1'b1, 1'b0, 8'd0, OHold});
    tbl.push_back('{1'b0, 1'b1, 8'd7, OHold});
    tbl.push_back('{1'b0, 1'b0, 8'd0, OHold});
    tbl.push_back('{1'b0, 1'b0, 8'd0, OHold});
    tbl.push_back('{1'b0, 1'b0, 8'd0, OHold});
    tbl.push_back('{1'b0, 1'b0, 8'd0, OWait});
    tbl.push_back('{1'b0, 1'b0, 8'd2, OWait});
    tbl.push_back('{1'b0, 1'b0, 8'd3, ODfu});
    tbl.push_back('{1'b0, 1'b0, 8'd0, ODfu});
    tbl.push_back('{1'b0, 1'b1, 8'd0, ODisc});
    tbl.push_back('{1'b0, 1'b1, 8'd9, ODisc});
    tbl.push_back('{1'b0, 1'b0, 8'd0, ODisc});
    tbl.push_back('{1'b0, 1'b0, 8'd0, ODisc});
    tbl.push_back('{1'b0, 1'b0, 8'd0, OBoot});
    tbl.push_back('{1'b0, 1'b1, 8'd9, OBoot});
    tbl.push_back('{1'b1, 1'b0, 8'd0, OHold});
    foreach (tbl[k]) begin
      rst[0] = tbl[k].r; det[0] = tbl[k].d; st[0] = tbl[k].s;
      tick();
      check("vec", 32'(dut_out(0)), 32'(tbl[k].exp));
    end

    // Autoboot timing on A.
    reset_pulse(0);
    first_low = 0; high_cnt = 0; disc_cnt = 0; first_boot = 0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (!cr[0] && first_low == 0) first_low = c;
      if (pe[0]) high_cnt++;
      if (cs[0] == 3'd3) disc_cnt++;
      if (br[0] && first_boot == 0) first_boot = c;
    end
    check("auto_core_low", first_low, 5);
    check("auto_pull_high", high_cnt, 21);
    check("auto_pull_low", disc_cnt, 4);
    check("auto_boot_at", first_boot, 30);
    check("auto_boot_sticky", 32'(br[0]), 1);

    // Autoboot cancelled by DFU activity at WAIT cycle 10.
    reset_pulse(0);
    for (int c = 0; c < 15; c++) tick();
    st[0] = 8'd3;
    tick();
    st[0] = 8'd0;
    check("cancel_state", 32'(cs[0]), 2);
    check("cancel_armed", 32'(aa[0]), 0);
    seen_boot = 0;
    for (int c = 0; c < 1000; c++) begin
      tick();
      if (br[0]) seen_boot = 1;
    end
    check("cancel_no_boot", seen_boot, 0);

    // Detach from DFU.
    det[0] = 1'b1;
    tick();
    det[0] = 1'b0;
    check("detach_state", 32'(cs[0]), 3);
    check("detach_pull", 32'(pe[0]), 0);
    for (int c = 0; c < 4; c++) tick();
    check("detach_boot", 32'(br[0]), 1);

    // DFU activity on the timeout cycle wins.
    reset_pulse(0);
    for (int c = 0; c < 25; c++) tick();
    st[0] = 8'd5;
    tick();
    st[0] = 8'd0;
    check("collide_dfu", 32'(cs[0]), 2);
    // Detach outranks DFU activity.
    reset_pulse(0);
    for (int c = 0; c < 10; c++) tick();
    det[0] = 1'b1; st[0] = 8'd5;
    tick();
    idle(0);
    check("collide_detach", 32'(cs[0]), 3);

    // Reset mid-DISC, then in BOOT.
    reset_pulse(0);
    for (int c = 0; c < 27; c++) tick();
    check("pre_disc", 32'(cs[0]), 3);
    reset_pulse(0);
    check("disc_rst", 32'({cs[0], br[0], cr[0]}), 32'b000_0_1);
    for (int c = 0; c < 30; c++) tick();
    check("disc_rst_reboot", 32'(br[0]), 1);
    reset_pulse(0);
    check("boot_rst", 32'({cs[0], br[0], cr[0]}), 32'b000_0_1);
    for (int c = 0; c < 30; c++) tick();
    check("boot_rst_reboot", 32'(br[0]), 1);

    // Autoboot disabled on B.
    reset_pulse(1);
    for (int c = 0; c < 200; c++) tick();
    check("noauto_wait", 32'(cs[1]), 1);
    check("noauto_armed", 32'(aa[1]), 0);
    det[1] = 1'b1;
    tick();
    det[1] = 1'b0;
    check("noauto_disc", 32'(cs[1]), 3);
    for (int c = 0; c < 4; c++) tick();
    check("noauto_boot", 32'(br[1]), 1);

    // Random stimulus, both instances against the model.
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < 2; i++) begin
        rst[i] = ($urandom_range(0, 299) == 0);
        det[i] = ($urandom_range(0, 79) == 0);
        st[i]  = ($urandom_range(0, 39) == 0) ? 8'($urandom_range(3, 255))
                                              : 8'($urandom_range(0, 2));
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
